ternary_stream_decoder: RTL and testbench

//  Decodes a serial stream of balanced-ternary trits (MSB first, 2-bit code per trit)

---
 rtl/ternary_stream_decoder.sv | 89 ++++++++
 tb/tb_ternary_stream_decoder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ternary_stream_decoder.sv
// ternary_stream_decoder: balanced-ternary trit-serial to two's-complement word decoder; TERNARY_DEC_BYPASS_EN enables same-edge restart on output handshake
module ternary_stream_decoder #(
  parameter int TRITS = 6,
  parameter int OUT_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_trit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                  r_state;
  logic signed [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic                    r_rdy_en;
  logic [OUT_W-1:0]        r_out_data;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_out_err;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] w_t;
  logic signed [OUT_W-1:0] w_acc_base;
  logic signed [OUT_W-1:0] w_acc_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_err_next;
  logic                    w_fire;
  logic                    w_close;
  logic                    w_cont;
`ifdef TERNARY_DEC_BYPASS_EN
  assign in_ready = r_rdy_en && (!r_out_valid || out_ready);
`else
  assign in_ready = r_rdy_en && (r_state != DONE);
`endif
  // Only ACCUM continues a word; IDLE and a bypassed DONE both start from zero so the held result is untouched
  assign w_cont     = (r_state == ACCUM);
  assign w_t        = (in_trit == 2'b10) ? OUT_W'(1) : (in_trit == 2'b00) ? '1 : '0;
  assign w_acc_base = w_cont ? r_acc : '0;
  assign w_acc_next = (w_acc_base <<< 1) + w_acc_base + w_t;
  assign w_cnt_next = (w_cont ? r_cnt : '0) + CNT_W'(1);
  assign w_err_next = (w_cont && r_err) || (in_trit == 2'b11);
  assign w_fire     = in_valid && in_ready;
  assign w_close    = in_last || (w_cnt_next == CNT_W'(TRITS));
  assign out_data   = r_out_data;
  assign out_count  = r_out_count;
  assign out_err    = r_out_err;
  assign out_valid  = r_out_valid;
  // Word FSM: accumulate trits, latch the closed word into the output registers, release on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_fire) begin
        r_acc       <= w_acc_next;
        r_cnt       <= w_cnt_next;
        r_err       <= w_err_next;
        r_state     <= w_close ? DONE : ACCUM;
        r_out_valid <= w_close;
        if (w_close) begin
          r_out_data  <= w_acc_next;
          r_out_count <= w_cnt_next;
          r_out_err   <= w_err_next;
        end
      end else if (r_state == DONE && out_ready) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_err       <= 1'b0;
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ternary_stream_decoder.sv
// tb_ternary_stream_decoder: directed-vector bench for ternary_stream_decoder (default build)
module tb_ternary_stream_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] in_trit = 2'b01;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [9:0] out_data;
  logic [2:0] out_count;
  logic       out_err;
  logic       out_valid;
  logic       out_ready = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

  ternary_stream_decoder #(.TRITS(6), .OUT_W(10), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_trit(in_trit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_count(out_count), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] code, input logic last);
    int n = 0;
    in_trit  = code;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string tag, input logic [9:0] d, input logic [2:0] c, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_err"}, 32'(out_err), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    chk("ready_pre_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_post_edge", 32'(in_ready), 32'd1);
    send(2'b10, 1'b0);
    send(2'b01, 1'b0);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    send(2'b00, 1'b1);
    take("t1", 10'd8, 3'd3, 1'b0);
    chk("t1_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) send(2'b00, i == 2);
    take("t2a", 10'h3F3, 3'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("t2b_not_yet", 32'(out_valid), 32'd0);
      send(2'b10, 1'b0);
    end
    take("t2b", 10'd364, 3'd6, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b10, 1'b1);
    take("t3", 10'd10, 3'd3, 1'b1);
    send(2'b10, 1'b1);
    take("t3_clear", 10'd1, 3'd1, 1'b0);
    send(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_data", 32'(out_data), 32'h3FF);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    take("t4", 10'h3FF, 3'd1, 1'b0);
    chk("t4_idle_ready", 32'(in_ready), 32'd1);
    send(2'b10, 1'b0);
    send(2'b10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    send(2'b01, 1'b1);
    take("t5", 10'd0, 3'd1, 1'b0);
    send(2'b10, 1'b0);
    in_trit = 2'b00;
    in_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_gap", 32'(out_valid), 32'd0);
    send(2'b10, 1'b1);
    take("t6", 10'd4, 3'd2, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
